// File: rtl/mac_viol_handler.sv
// Violation handler: turns each new access violation into a fixed-length
// CPU reset request, captures the first violation's PC/addresses, counts
// violations, and exposes everything on an openMSP430 peripheral slave.
module mac_viol_handler #(
  parameter int unsigned RST_LEN   = 16,
  parameter logic [13:0] BASE_ADDR = 14'h00C8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        viol,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic [15:0] code_addr,
  output logic        sys_rst_o,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ASSERT = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  localparam logic [7:0] RST_LOAD = 8'(RST_LEN - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  rst_cnt_r;
  logic [7:0]  rst_cnt_next_s;
  logic        viol_q_r;
  logic        viol_rise_s;
  logic        valid_r;
  logic [7:0]  count_r;
  logic [7:0]  count_inc_s;
  logic [15:0] pc_capt_r;
  logic [15:0] daddr_capt_r;
  logic [15:0] caddr_capt_r;
  logic [13:0] offset_s;
  logic        in_range_s;
  logic        status_clr_s;
  logic        busy_s;
  logic        unused_s;

  // Write data is never stored: a STATUS write clears regardless of value.
  assign unused_s     = ^per_din;

  assign viol_rise_s  = viol & ~viol_q_r;
  assign busy_s       = (state_r != ST_IDLE);
  assign offset_s     = per_addr - BASE_ADDR;
  assign in_range_s   = (offset_s < 14'd4);
  assign status_clr_s = per_en & (per_we != 2'b00) & (offset_s == 14'd0);
  assign count_inc_s  = (count_r == 8'hFF) ? 8'hFF : (count_r + 8'd1);

  // Next-state logic: a new edge only triggers from IDLE; HOLD waits for viol to drop.
  always_comb begin
    next_state_s   = state_r;
    rst_cnt_next_s = rst_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (viol_rise_s) begin
          next_state_s   = ST_ASSERT;
          rst_cnt_next_s = RST_LOAD;
        end else begin
          next_state_s   = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (rst_cnt_r == 8'd0) begin
          next_state_s   = ST_HOLD;
        end else begin
          rst_cnt_next_s = rst_cnt_r - 8'd1;
        end
      end
      ST_HOLD: begin
        if (!viol) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s   = ST_IDLE;
        rst_cnt_next_s = 8'd0;
      end
    endcase
  end

  // FSM state, pulse counter, edge-detect flop and registered reset request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rst_cnt_r <= 8'd0;
      viol_q_r  <= 1'b0;
      sys_rst_o <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      rst_cnt_r <= rst_cnt_next_s;
      viol_q_r  <= viol;
      sys_rst_o <= (next_state_s == ST_ASSERT);
    end
  end

  // Capture and count; a violation in the same cycle as a STATUS clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r      <= 1'b0;
      count_r      <= 8'd0;
      pc_capt_r    <= 16'h0000;
      daddr_capt_r <= 16'h0000;
      caddr_capt_r <= 16'h0000;
    end else if (viol_rise_s) begin
      if (!valid_r || status_clr_s) begin
        pc_capt_r    <= pc;
        daddr_capt_r <= data_addr;
        caddr_capt_r <= code_addr;
      end else begin
        pc_capt_r    <= pc_capt_r;
        daddr_capt_r <= daddr_capt_r;
        caddr_capt_r <= caddr_capt_r;
      end
      valid_r <= 1'b1;
      count_r <= status_clr_s ? 8'd1 : count_inc_s;
    end else if (status_clr_s) begin
      valid_r <= 1'b0;
      count_r <= 8'd0;
    end else begin
      valid_r <= valid_r;
      count_r <= count_r;
    end
  end

  // Peripheral read mux; returns zero unless this block is addressed.
  always_comb begin
    per_dout = 16'h0000;
    if (per_en && in_range_s) begin
      case (offset_s[1:0])
        2'd0:    per_dout = {count_r, 6'b000000, busy_s, valid_r};
        2'd1:    per_dout = pc_capt_r;
        2'd2:    per_dout = daddr_capt_r;
        2'd3:    per_dout = caddr_capt_r;
        default: per_dout = 16'h0000;
      endcase
    end else begin
      per_dout = 16'h0000;
    end
  end

endmodule

// File: tb/tb_mac_viol_handler.sv
// Self-checking bench for mac_viol_handler: a pulse/register model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mac_viol_handler;

  localparam int          RST_LEN = 16;
  localparam logic [13:0] BASE    = 14'h00C8;

  logic        clk = 1'b0;
  logic        rst;
  logic        viol;
  logic [15:0] pc, data_addr, code_addr;
  logic        sys_rst_o;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  int total = 0;
  int bad   = 0;
  int hi    = 0;
  bit chk_en = 1'b0;

  mac_viol_handler #(.RST_LEN(RST_LEN), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .viol(viol), .pc(pc), .data_addr(data_addr),
    .code_addr(code_addr), .sys_rst_o(sys_rst_o), .per_addr(per_addr),
    .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_left  = 0;   // reset-pulse cycles still to come
  bit          m_hold  = 1'b0;
  bit          m_pviol = 1'b0;
  bit          m_valid = 1'b0;
  int          m_count = 0;
  logic [15:0] m_pc = 16'h0, m_da = 16'h0, m_ca = 16'h0;

  wire m_rise = viol & ~m_pviol;
  wire m_clr  = per_en && (per_we != 2'b00) && (per_addr == BASE);

  // Model update on every rising edge using the inputs presented to the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_hold <= 1'b0; m_pviol <= 1'b0;
      m_valid <= 1'b0; m_count <= 0;
      m_pc <= 16'h0; m_da <= 16'h0; m_ca <= 16'h0;
    end else begin
      m_pviol <= viol;
      if (m_hold) begin
        if (!viol) m_hold <= 1'b0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_hold <= 1'b1;
      end else if (m_rise) begin
        m_left <= RST_LEN;
      end
      if (m_rise) begin
        if (!m_valid || m_clr) begin
          m_pc <= pc; m_da <= data_addr; m_ca <= code_addr;
        end
        m_valid <= 1'b1;
        m_count <= m_clr ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      end else if (m_clr) begin
        m_valid <= 1'b0;
        m_count <= 0;
      end
    end
  end

  function automatic logic [15:0] m_read(logic en, logic [13:0] addr);
    int off;
    logic [7:0] c8;
    off = int'(addr) - int'(BASE);
    c8  = 8'(m_count);
    if (!en) return 16'h0000;
    case (off)
      0:       return {c8, 6'b000000, ((m_left > 0) || m_hold), m_valid};
      1:       return m_pc;
      2:       return m_da;
      3:       return m_ca;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_sys_rst", {15'h0, sys_rst_o}, {15'h0, (m_left > 0)});
      chk("cyc_per_dout", per_dout, m_read(per_en, per_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      hi += int'(sys_rst_o);
    end
  endtask

  task automatic rd(string nm, int off, logic [15:0] exp);
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = BASE + 14'(off);
    #2;
    chk(nm, per_dout, exp);
  endtask

  task automatic clear_status();
    per_en = 1'b1; per_addr = BASE; per_we = 2'b11; per_din = 16'hFFFF;
    run(1);
    per_we = 2'b00;
  endtask

  initial begin
    rst = 1'b1; viol = 1'b0; pc = 16'h0; data_addr = 16'h0; code_addr = 16'h0;
    per_addr = BASE; per_din = 16'h0; per_en = 1'b1; per_we = 2'b00;
    run(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_sys_rst", {15'h0, sys_rst_o}, 16'h0000);
    rd("reset_status", 0, 16'h0000);
    rd("reset_pc", 1, 16'h0000);
    run(1);

    // Single pulse
    pc = 16'h4400; data_addr = 16'h0600; code_addr = 16'h4400;
    hi = 0; viol = 1'b1; run(1); viol = 1'b0;
    chk("s1_rst_on", {15'h0, sys_rst_o}, 16'h0001);
    rd("s1_status_busy", 0, 16'h0103);
    run(24);
    chk("s1_pulse_len", 16'(hi), 16'd16);
    rd("s1_status_idle", 0, 16'h0101);
    rd("s1_pc", 1, 16'h4400);
    rd("s1_daddr", 2, 16'h0600);
    rd("s1_caddr", 3, 16'h4400);

    // Repeat during reset
    clear_status();
    rd("s2_cleared", 0, 16'h0000);
    hi = 0; viol = 1'b1; run(1); viol = 1'b0; run(4);
    pc = 16'h4500; viol = 1'b1; run(1); viol = 1'b0; run(25);
    chk("s2_pulse_len", 16'(hi), 16'd16);
    rd("s2_status", 0, 16'h0201);
    rd("s2_pc_kept", 1, 16'h4400);

    // Held level
    clear_status();
    hi = 0; viol = 1'b1; run(40);
    chk("s3_one_pulse", 16'(hi), 16'd16);
    rd("s3_hold_busy", 0, 16'h0103);
    viol = 1'b0; run(3);
    rd("s3_idle", 0, 16'h0101);
    viol = 1'b1; run(1); viol = 1'b0; run(25);
    chk("s3_second_pulse", 16'(hi), 16'd32);
    rd("s3_count2", 0, 16'h0201);

    // Clear versus event in the same cycle
    pc = 16'hA010; viol = 1'b1;
    per_en = 1'b1; per_addr = BASE; per_we = 2'b11; run(1);
    per_we = 2'b00; viol = 1'b0;
    rd("s4_event_wins", 0, 16'h0103);
    rd("s4_pc_new", 1, 16'hA010);
    run(25);
    clear_status();
    rd("s4_clear_only", 0, 16'h0000);
    rd("s4_pc_kept", 1, 16'hA010);

    // Saturation, unmapped reads, read-only capture
    pc = 16'h5555;
    for (int k = 0; k < 300; k++) begin
      viol = 1'b1; run(1); viol = 1'b0; run(1);
    end
    run(25);
    rd("s5_saturated", 0, 16'hFF01);
    rd("s5_unmapped_hi", 4, 16'h0000);
    rd("s5_unmapped_lo", -1, 16'h0000);
    per_en = 1'b1; per_addr = BASE + 14'd1; per_din = 16'h1234; per_we = 2'b11;
    run(1);
    per_we = 2'b00;
    rd("s5_pc_readonly", 1, 16'h5555);
    per_en = 1'b0; per_addr = BASE; #2;
    chk("s5_no_en", per_dout, 16'h0000);
    per_en = 1'b1;

    // Reset in the middle of ASSERT
    clear_status();
    pc = 16'h7777; viol = 1'b1; run(1); viol = 1'b0; run(6);
    chk("s6_in_assert", {15'h0, sys_rst_o}, 16'h0001);
    rst = 1'b1; run(1);
    chk("s6_rst_drop", {15'h0, sys_rst_o}, 16'h0000);
    rd("s6_status", 0, 16'h0000);
    rd("s6_pc", 1, 16'h0000);
    rst = 1'b0; per_addr = BASE;
    run(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
